// File: rtl/bsg_adder_multi_op_pipelined.sv
// Multi-operand adder: sums capacity_p operands exactly using a Wallace
// 3:2 carry-save tree followed by one carry-propagate add, split across
// stages_p register ranks with valid/ready flow control and bubble collapse.
module bsg_adder_multi_op_pipelined #(
    parameter int width_p       = 8,
    parameter int capacity_p    = 8,
    parameter int stages_p      = 2,
    parameter int output_size_p = width_p + ((capacity_p <= 1) ? 1 : $clog2(capacity_p))
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          v_i,
    output logic                          ready_o,
    input  logic                          signed_i,
    input  logic [capacity_p*width_p-1:0] ops_i,
    output logic                          v_o,
    input  logic                          ready_i,
    output logic [output_size_p-1:0]      sum_o
);

    // Row count left after the given number of 3:2 levels.
    function automatic int rowsAfter(input int levels);
        int n;
        n = capacity_p;
        for (int i = 0; i < levels; i++) begin
            if (n > 2) n = 2 * (n / 3) + (n % 3);
        end
        return n;
    endfunction

    // Number of 3:2 levels needed to reach two rows.
    function automatic int countLevels();
        int n;
        int l;
        n = capacity_p;
        l = 0;
        for (int i = 0; i < 64; i++) begin
            if (n > 2) begin
                n = 2 * (n / 3) + (n % 3);
                l++;
            end
        end
        return l;
    endfunction

    localparam int csaLevels = countLevels();
    localparam int lastLevel = csaLevels + 1;

    // Tree level whose result register rank r captures.
    function automatic int rankLevel(input int r);
        return (stages_p > 0) ? (r * lastLevel + stages_p - 1) / stages_p : 0;
    endfunction

    // Rank registering a given level, or 0 when that level is purely combinational.
    function automatic int rankOfLevel(input int l);
        int found;
        found = 0;
        for (int r = 1; r <= stages_p; r++) begin
            if (rankLevel(r) == l) found = r;
        end
        return found;
    endfunction

    // Rows present at the output of level l (the CPA collapses to one row).
    function automatic int rowsAt(input int l);
        return (l == lastLevel) ? 1 : rowsAfter(l);
    endfunction

    if (capacity_p < 2 || width_p < 1 || stages_p < 1 || stages_p > lastLevel
        || output_size_p < width_p) begin : paramCheckGen
        $error("bsg_adder_multi_op_pipelined: illegal parameters width_p=%0d capacity_p=%0d stages_p=%0d (max %0d)",
               width_p, capacity_p, stages_p, lastLevel);
    end

    // rankValid[r] marks rank r as holding a live transaction.
    logic [stages_p:1]   rankValid;
    // srcValid[r-1] is the valid feeding rank r; bit 0 is the input port.
    logic [stages_p:0]   srcValid;
    // rankLoad[r] means rank r captures this cycle; the top bit is the consumer.
    logic [stages_p+1:1] rankLoad;

    // Walk back from the consumer: a rank can load when empty or when it is draining forward.
    always_comb begin
        srcValid = {rankValid, v_i};
        rankLoad = '0;
        rankLoad[stages_p+1] = ready_i;
        for (int r = stages_p; r >= 1; r--) begin
            rankLoad[r] = ~rankValid[r] | rankLoad[r+1];
        end
    end

    assign ready_o = rankLoad[1];
    assign v_o     = srcValid[stages_p];

    // Valid bits follow their upstream source whenever the rank loads, so bubbles collapse.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rankValid <= '0;
        end else begin
            for (int r = 1; r <= stages_p; r++) begin
                if (rankLoad[r]) rankValid[r] <= srcValid[r-1];
            end
        end
    end

    for (genvar l = 0; l <= lastLevel; l++) begin : levelGen
        localparam int rowsOut = rowsAt(l);
        logic [rowsOut-1:0][output_size_p-1:0] outRows;

        if (l == 0) begin : extendGen
            // Widen every operand to the result width; the sign bit is replicated only in signed mode.
            always_comb begin
                outRows = '0;
                for (int k = 0; k < capacity_p; k++) begin
                    outRows[k] = signed_i
                        ? output_size_p'($signed(ops_i[k*width_p +: width_p]))
                        : output_size_p'(ops_i[k*width_p +: width_p]);
                end
            end
        end else begin : reduceGen
            localparam int rowsIn  = rowsAt(l - 1);
            localparam int srcRank = rankOfLevel(l - 1);
            logic [rowsIn-1:0][output_size_p-1:0] inRows;

            if (srcRank != 0) begin : fromRankGen
                assign inRows = rankGen[srcRank].data;
            end else begin : fromLevelGen
                assign inRows = levelGen[l-1].outRows;
            end

            if (l == lastLevel) begin : cpaGen
                assign outRows = inRows[0] + inRows[1];
            end else begin : csaGen
                localparam int groups = rowsIn / 3;
                // Each full group of three rows becomes a sum row and a shifted carry row; leftovers pass through.
                always_comb begin
                    outRows = '0;
                    for (int g = 0; g < groups; g++) begin
                        outRows[2*g]   = inRows[3*g] ^ inRows[3*g+1] ^ inRows[3*g+2];
                        outRows[2*g+1] = ((inRows[3*g] & inRows[3*g+1])
                                        | (inRows[3*g] & inRows[3*g+2])
                                        | (inRows[3*g+1] & inRows[3*g+2])) << 1;
                    end
                    for (int k = 3 * groups; k < rowsIn; k++) begin
                        outRows[2*groups + k - 3*groups] = inRows[k];
                    end
                end
            end
        end
    end

    for (genvar r = 1; r <= stages_p; r++) begin : rankGen
        localparam int levelIdx = rankLevel(r);
        logic [rowsAt(levelIdx)-1:0][output_size_p-1:0] data;

        // Data only moves when a live transaction arrives, so empty ranks do not toggle.
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                data <= '0;
            end else if (rankLoad[r] & srcValid[r-1]) begin
                data <= levelGen[levelIdx].outRows;
            end
        end
    end

    assign sum_o = rankGen[stages_p].data;

endmodule

// File: tb/tb_bsg_adder_multi_op_pipelined.sv
// Bench for bsg_adder_multi_op_pipelined: three configurations share one
// stimulus stream; each keeps its own scoreboard of expected sums.
module tb_bsg_adder_multi_op_pipelined;

    logic        clk = 1'b0;
    logic        rstN;
    logic        vIn;
    logic        signedIn;
    logic        readyIn;
    logic [63:0] opsA;
    logic [39:0] opsB;
    logic [51:0] opsC;

    logic        readyA, vA;
    logic [10:0] sumA;
    logic        readyB, vB;
    logic [10:0] sumB;
    logic        readyC, vC;
    logic [7:0]  sumC;

    int checks = 0;
    int errors = 0;
    int qA[$];
    int qB[$];
    int qC[$];
    int outCountB = 0;
    int expectedA, expectedB, expectedC;
    int baseB;

    always #5 clk = ~clk;

    bsg_adder_multi_op_pipelined #(.width_p(8), .capacity_p(8), .stages_p(2)) dutA (
        .clk_i(clk), .reset_n_i(rstN), .v_i(vIn), .ready_o(readyA), .signed_i(signedIn),
        .ops_i(opsA), .v_o(vA), .ready_i(readyIn), .sum_o(sumA));

    bsg_adder_multi_op_pipelined #(.width_p(8), .capacity_p(5), .stages_p(3)) dutB (
        .clk_i(clk), .reset_n_i(rstN), .v_i(vIn), .ready_o(readyB), .signed_i(signedIn),
        .ops_i(opsB), .v_o(vB), .ready_i(readyIn), .sum_o(sumB));

    bsg_adder_multi_op_pipelined #(.width_p(4), .capacity_p(13), .stages_p(3)) dutC (
        .clk_i(clk), .reset_n_i(rstN), .v_i(vIn), .ready_o(readyC), .signed_i(signedIn),
        .ops_i(opsC), .v_o(vC), .ready_i(readyIn), .sum_o(sumC));

    // Single comparison point: counts every check and reports any difference.
    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Integer reference sum of c operands of w bits, reduced to outW bits.
    function automatic int refSum(input logic [63:0] ops, input int w, input int c,
                                  input logic sgn, input int outW);
        longint acc;
        longint op;
        acc = 0;
        for (int k = 0; k < c; k++) begin
            op = longint'((ops >> (k * w)) & ((64'd1 << w) - 64'd1));
            if (sgn && (((op >> (w - 1)) & 1) == 1)) op = op - (longint'(1) << w);
            acc += op;
        end
        return int'(acc & ((longint'(1) << outW) - 1));
    endfunction

    // Drive one cycle of inputs just after the rising edge, with fresh random operands.
    task automatic applyStimulus(input logic v, input logic s, input logic r);
        @(posedge clk);
        #1;
        vIn      = v;
        signedIn = s;
        readyIn  = r;
        opsA     = {$urandom(), $urandom()};
        opsB     = 40'({$urandom(), $urandom()});
        opsC     = 52'({$urandom(), $urandom()});
    endtask

    // Scoreboards: on the falling edge, predict what the next rising edge accepts and consumes.
    always @(negedge clk) begin
        if (!rstN) begin
            qA.delete();
            qB.delete();
            qC.delete();
        end else begin
            if (vA && readyIn) begin
                if (qA.size() == 0) checkOutput("A unexpected output", int'(vA), 0);
                else begin
                    expectedA = qA.pop_front();
                    checkOutput("A sum", int'(sumA), expectedA);
                end
            end
            if (vB && readyIn) begin
                outCountB++;
                if (qB.size() == 0) checkOutput("B unexpected output", int'(vB), 0);
                else begin
                    expectedB = qB.pop_front();
                    checkOutput("B sum", int'(sumB), expectedB);
                end
            end
            if (vC && readyIn) begin
                if (qC.size() == 0) checkOutput("C unexpected output", int'(vC), 0);
                else begin
                    expectedC = qC.pop_front();
                    checkOutput("C sum", int'(sumC), expectedC);
                end
            end
            if (vIn && readyA) qA.push_back(refSum(opsA, 8, 8, signedIn, 11));
            if (vIn && readyB) qB.push_back(refSum(64'(opsB), 8, 5, signedIn, 11));
            if (vIn && readyC) qC.push_back(refSum(64'(opsC), 4, 13, signedIn, 8));
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstN     = 1'b0;
        vIn      = 1'b0;
        signedIn = 1'b0;
        readyIn  = 1'b1;
        opsA     = '0;
        opsB     = '0;
        opsC     = '0;

        // Reset state
        #1;
        checkOutput("reset readyA", int'(readyA), 1);
        checkOutput("reset vB", int'(vB), 0);
        checkOutput("reset sumB", int'(sumB), 0);
        checkOutput("reset vC", int'(vC), 0);
        @(posedge clk);
        #1;
        rstN = 1'b1;

        // Directed: unsigned then signed transaction back to back
        applyStimulus(1'b1, 1'b0, 1'b1);
        opsA = '1;
        opsB = {5{8'h80}};
        for (int k = 0; k < 13; k++) opsC[k*4 +: 4] = 4'(k);
        applyStimulus(1'b1, 1'b1, 1'b1);
        opsA = '1;
        opsB = {5{8'h80}};
        for (int k = 0; k < 13; k++) opsC[k*4 +: 4] = 4'(k);
        checkOutput("A latency not early", int'(vA), 0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("A valid after 2", int'(vA), 1);
        checkOutput("A unsigned FF sum", int'(sumA), 2040);
        @(posedge clk);
        #1;
        checkOutput("A signed FF sum", int'(sumA), 'h7F8);
        checkOutput("B valid after 3", int'(vB), 1);
        checkOutput("B unsigned 0x80 sum", int'(sumB), 640);
        checkOutput("C valid after 3", int'(vC), 1);
        checkOutput("C unsigned 0..12 sum", int'(sumC), 78);
        @(posedge clk);
        #1;
        checkOutput("B signed -640 sum", int'(sumB), 'h580);
        checkOutput("C signed 0..12 sum", int'(sumC), 'hFE);
        checkOutput("A drained", int'(vA), 0);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b1);

        // Back-pressure: fill B with ready_i low
        baseB = outCountB;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b0);
            checkOutput("B ready while filling", int'(readyB), 1);
        end
        @(posedge clk);
        #1;
        checkOutput("B ready when full", int'(readyB), 0);
        checkOutput("B valid when full", int'(vB), 1);
        applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        checkOutput("B still stalled", int'(readyB), 0);

        // Full pipe with simultaneous accept and emit
        applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b1);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b1);
            checkOutput("B full valid", int'(vB), 1);
            checkOutput("B full ready", int'(readyB), 1);
        end
        applyStimulus(1'b0, 1'b0, 1'b1);
        repeat (6) applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("B output count", outCountB - baseB, 24);
        checkOutput("B queue drained", qB.size(), 0);

        // Reset with transactions in flight
        applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        rstN = 1'b0;
        #1;
        checkOutput("midreset vA", int'(vA), 0);
        checkOutput("midreset sumA", int'(sumA), 0);
        checkOutput("midreset vB", int'(vB), 0);
        checkOutput("midreset sumB", int'(sumB), 0);
        @(posedge clk);
        #1;
        rstN = 1'b1;
        checkOutput("post reset readyB", int'(readyB), 1);
        checkOutput("post reset readyC", int'(readyC), 1);
        repeat (5) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            checkOutput("no stale vA", int'(vA), 0);
            checkOutput("no stale vB", int'(vB), 0);
            checkOutput("no stale vC", int'(vC), 0);
        end

        // Random traffic against the reference model
        repeat (10000) begin
            applyStimulus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                          $urandom_range(0, 3) != 0);
        end
        repeat (8) applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("A final queue", qA.size(), 0);
        checkOutput("B final queue", qB.size(), 0);
        checkOutput("C final queue", qC.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
